tap_loader: RTL and testbench
=============================

Name: tap_loader

Overview:
Parametrised Lynx tape-image (TAP) loader. It parses a TAP stream arriving on the ioctl download port and writes the program body into system RAM. Supports BASIC, machine-code, data and Level 9 file types, with memory write backpressure, header capture and error reporting. It sits between the HPS ioctl interface and the RAM write arbiter, replacing the fixed-address, no-backpressure loader.

Parameters:
ADDR_W, 16, width of RAM address and of load/exec/length fields
DEFAULT_LOAD, 16'h694D, load address for BASIC/Level 9 files and, when FORCE_LOAD=1, for all types
FORCE_LOAD, 1, 1 = ignore load address from the header and use DEFAULT_LOAD; 0 = honour header
MAX_NAME, 64, maximum bytes between opening and closing quote before a name error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download active
ioctl_wr  in  1  byte strobe
ioctl_dout  in  8  download byte
ioctl_wait  out  1  backpressure to HPS; a byte is consumed only when ioctl_wr=1 and ioctl_wait=0
mem_addr  out  ADDR_W  RAM write address
mem_dout  out  8  RAM write data
mem_wr  out  1  write request, held until mem_ack
mem_ack  in  1  RAM accepted the write this cycle
file_type  out  8  captured type byte
load_addr  out  ADDR_W  effective load address
exec_addr  out  ADDR_W  exec address (valid for 'M' files only)
exec_valid  out  1  exec_addr captured
done  out  1  load finished (pulses never; level until next download)
error  out  3  bit0 bad type / name overrun, bit1 truncated or overflow, bit2 checksum mismatch

Behaviour:
- Reset: all outputs 0. State is IDLE. Checksum, count and address registers are 0.
- Rising edge of ioctl_download returns the block to IDLE from any state and clears done, error and exec_valid.
- States: IDLE, NAME, TYPE, LEN_LO, LEN_HI, LOAD_LO, LOAD_HI, EXEC_LO, EXEC_HI, DATA, CHECK, TRAIL, DONE.
- IDLE: byte 8'h22 -> NAME; other bytes are ignored.
- NAME: 8'h22 -> TYPE. A byte count exceeding MAX_NAME -> set error[0] and go to DONE.
- TYPE: 8'hA5 is ignored and the block stays in TYPE. 'B', 'M', 'D' or 'A' are latched into file_type -> LEN_LO. Any other value sets error[0] -> DONE.
- LEN_LO/LEN_HI: little-endian length. Fields are zero-extended or truncated to ADDR_W.
- After LEN_HI:
  - 'B' and 'A': load_addr=DEFAULT_LOAD -> DATA.
  - 'M' and 'D': -> LOAD_LO.
- LOAD_LO/LOAD_HI: load_addr takes the header value, or DEFAULT_LOAD if FORCE_LOAD. Then 'M' -> EXEC_LO; 'D' -> DATA.
- EXEC_LO/EXEC_HI: capture exec_addr, set exec_valid -> DATA.
- DATA:
  - Each consumed byte drives mem_addr=load_addr+offset, mem_dout=byte, mem_wr=1 on the next cycle.
  - ioctl_wait=1 from that cycle until the cycle mem_ack=1. mem_wr drops the cycle after mem_ack.
  - The checksum accumulates as an 8-bit modular sum of data bytes.
  - Length 0 skips DATA entirely.
  - After the last byte: 'B' -> DONE; other types -> CHECK.
- Overflow: if the write address would wrap past 2^ADDR_W-1, set error[1], suppress further writes, and continue parsing.
- CHECK: compare the byte to the checksum; mismatch sets error[2] -> TRAIL.
- TRAIL: consume one byte -> DONE.
- DONE: set done=1. Ignore further bytes. mem_wr is never asserted in this state.
- ioctl_download falling in any state other than IDLE or DONE: set error[1] and go to DONE once any pending write is acknowledged.
- ioctl_wait is only asserted while a write is pending. The pending-write latency from byte accept to mem_wr is 1 cycle.

Optional Feature:
TAP_CHECKSUM_EN
- Defined: CHECK compares the byte and may set error[2].
- Undefined: the checksum accumulator is removed, the CHECK byte is consumed without comparison, and error[2] is tied to 0.

Decomposition:
- Package tap_pkg holds:
  - state enum
  - file-type constants: FT_BASIC=8'h42, FT_MCODE=8'h4D, FT_DATA=8'h44, FT_L9=8'h41
  - QUOTE=8'h22 and PAD=8'hA5
  - error bit indices
- One sub-module, tap_wr_buf: a single-entry write holding register providing mem_wr, mem_addr, mem_dout and the ioctl_wait generation.

Test Plan:
- BASIC: "" 'B' len 0003 bytes 11 22 33 -> writes 694D=11, 694E=22, 694F=33; done=1; error=0.
- MCODE, FORCE_LOAD=0: "AB" 'M' len 0002 load 8000 exec 8010 data AA BB chk 65 trail 00 -> writes 8000/8001; exec_addr=8010; exec_valid=1; error=0.
- Backpressure: hold mem_ack=0 for 5 cycles on each write -> ioctl_wait high throughout; no byte lost or duplicated; the address sequence is contiguous.
- Checksum: 'D' file with check byte 00 but sum 7F -> error=3'b100; done=1 (with TAP_CHECKSUM_EN).
- Bad type 'Z' after name -> error[0]=1; done=1; no mem_wr ever asserted.
- Truncation: drop ioctl_download after 2 of 4 data bytes -> error[1]=1; done=1. Then assert reset mid-load -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared definitions for the Lynx TAP loader: parser states, file-type
// codes, framing bytes and error-bit positions.
package tap_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_NAME    = 4'd1,
    ST_TYPE    = 4'd2,
    ST_LEN_LO  = 4'd3,
    ST_LEN_HI  = 4'd4,
    ST_LOAD_LO = 4'd5,
    ST_LOAD_HI = 4'd6,
    ST_EXEC_LO = 4'd7,
    ST_EXEC_HI = 4'd8,
    ST_DATA    = 4'd9,
    ST_CHECK   = 4'd10,
    ST_TRAIL   = 4'd11,
    ST_DONE    = 4'd12
  } state_e;

  // File-type bytes as they appear after the closing quote.
  localparam logic [7:0] FT_BASIC = 8'h42;  // 'B'
  localparam logic [7:0] FT_MCODE = 8'h4D;  // 'M'
  localparam logic [7:0] FT_DATA  = 8'h44;  // 'D'
  localparam logic [7:0] FT_L9    = 8'h41;  // 'A'

  // Framing bytes.
  localparam logic [7:0] QUOTE = 8'h22;
  localparam logic [7:0] PAD   = 8'hA5;

  // Positions within the error vector.
  localparam int ERR_TYPE  = 0;  // bad type byte or name overrun
  localparam int ERR_TRUNC = 1;  // download cut short or address overflow
  localparam int ERR_CSUM  = 2;  // checksum mismatch

  // True for the four file types the loader understands.
  function automatic logic is_known_type(input logic [7:0] b);
    return (b == FT_BASIC) || (b == FT_MCODE) || (b == FT_DATA) || (b == FT_L9);
  endfunction

endpackage

// File: rtl/tap_wr_buf.sv
// Single-entry RAM write holding register. A pushed byte is presented on
// the memory port the following cycle and held until the RAM acknowledges
// it; busy_o doubles as the download backpressure signal.
module tap_wr_buf #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        data_i,
  input  logic              mem_ack_i,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_dout_o,
  output logic              busy_o
);

  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  // Holding register: capture on push, release the cycle after acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Next-state: a push is only honoured when the slot is empty, which the
  // parser guarantees because it cannot accept a byte while busy.
  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (pending_q && mem_ack_i) begin
      pending_d = 1'b0;
    end
    if (push_i && !pending_q) begin
      pending_d = 1'b1;
      addr_d    = addr_i;
      data_d    = data_i;
    end
  end

  assign mem_wr_o   = pending_q;
  assign mem_addr_o = addr_q;
  assign mem_dout_o = data_q;
  assign busy_o     = pending_q;

endmodule

// File: rtl/tap_loader.sv
// Lynx TAP image loader: parses the ioctl download stream (name, type,
// length, optional load/exec addresses, body, checksum, trailer) and
// writes the body into RAM through a single-entry write buffer.
// Optional build macro TAP_CHECKSUM_EN enables checksum verification;
// without it the check byte is consumed unexamined and error[2] stays 0.
module tap_loader
  import tap_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] DEFAULT_LOAD = 16'h694D,
  parameter int                FORCE_LOAD   = 1,
  parameter int                MAX_NAME     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic              mem_ack,
  output logic [7:0]        file_type,
  output logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              exec_valid,
  output logic              done,
  output logic [2:0]        error
);

  localparam int NAME_W = $clog2(MAX_NAME + 1);

  state_e            state_q, state_d;
  logic              dl_q;
  logic              abort_q, abort_d;
  logic [7:0]        ft_q, ft_d;
  logic [ADDR_W-1:0] load_q, load_d;
  logic [ADDR_W-1:0] exec_q, exec_d;
  logic              exec_valid_q, exec_valid_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [7:0]        lo_q, lo_d;
  logic [NAME_W-1:0] name_cnt_q, name_cnt_d;
`ifdef TAP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              busy;
  logic              accept;
  logic              rise;
  logic              fall;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W:0]   wr_addr_ext;
  logic [ADDR_W-1:0] hdr_word;

  assign accept      = ioctl_download && ioctl_wr && !busy;
  assign rise        = ioctl_download && !dl_q;
  assign fall        = !ioctl_download && dl_q;
  // Extra top bit flags a body address that would wrap past the top of RAM.
  assign wr_addr_ext = {1'b0, load_q} + {1'b0, off_q};
  // Little-endian 16-bit header field, fitted to the address width.
  assign hdr_word    = ADDR_W'({ioctl_dout, lo_q});

  // Where the header hands over once all address fields are in: an empty
  // body goes straight to the checksum (or finishes, for BASIC).
  function automatic state_e after_hdr(input logic [ADDR_W-1:0] len,
                                       input logic [7:0]        ft);
    if (len == '0) begin
      return (ft == FT_BASIC) ? ST_DONE : ST_CHECK;
    end
    return ST_DATA;
  endfunction

  // Parser state and captured header fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b0;
      abort_q      <= 1'b0;
      ft_q         <= '0;
      load_q       <= '0;
      exec_q       <= '0;
      exec_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      rem_q        <= '0;
      off_q        <= '0;
      lo_q         <= '0;
      name_cnt_q   <= '0;
`ifdef TAP_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      abort_q      <= abort_d;
      ft_q         <= ft_d;
      load_q       <= load_d;
      exec_q       <= exec_d;
      exec_valid_q <= exec_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rem_q        <= rem_d;
      off_q        <= off_d;
      lo_q         <= lo_d;
      name_cnt_q   <= name_cnt_d;
`ifdef TAP_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state and write-request logic for the byte parser.
  always_comb begin
    state_d      = state_q;
    abort_d      = abort_q;
    ft_d         = ft_q;
    load_d       = load_q;
    exec_d       = exec_q;
    exec_valid_d = exec_valid_q;
    done_d       = done_q;
    err_d        = err_q;
    rem_d        = rem_q;
    off_d        = off_q;
    lo_d         = lo_q;
    name_cnt_d   = name_cnt_q;
`ifdef TAP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    push         = 1'b0;
    push_addr    = wr_addr_ext[ADDR_W-1:0];

    if (rise) begin
      // A fresh download always starts from a clean slate.
      state_d      = ST_IDLE;
      abort_d      = 1'b0;
      done_d       = 1'b0;
      err_d        = '0;
      exec_valid_d = 1'b0;
    end else if (abort_q) begin
      // Truncated download: finish only once the last write has landed.
      if (!busy) begin
        state_d = ST_DONE;
        abort_d = 1'b0;
      end
    end else if (fall && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      err_d[ERR_TRUNC] = 1'b1;
      if (busy) begin
        abort_d = 1'b1;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && (ioctl_dout == QUOTE)) begin
            state_d    = ST_NAME;
            name_cnt_d = '0;
            off_d      = '0;
            rem_d      = '0;
`ifdef TAP_CHECKSUM_EN
            csum_d     = '0;
`endif
          end
        end

        ST_NAME: begin
          if (accept) begin
            if (ioctl_dout == QUOTE) begin
              state_d = ST_TYPE;
            end else if (name_cnt_q == NAME_W'(MAX_NAME)) begin
              err_d[ERR_TYPE] = 1'b1;
              state_d         = ST_DONE;
            end else begin
              name_cnt_d = name_cnt_q + NAME_W'(1);
            end
          end
        end

        ST_TYPE: begin
          if (accept && (ioctl_dout != PAD)) begin
            if (is_known_type(ioctl_dout)) begin
              ft_d    = ioctl_dout;
              state_d = ST_LEN_LO;
            end else begin
              err_d[ERR_TYPE] = 1'b1;
              state_d         = ST_DONE;
            end
          end
        end

        ST_LEN_LO: begin
          if (accept) begin
            lo_d    = ioctl_dout;
            state_d = ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          if (accept) begin
            rem_d = hdr_word;
            if ((ft_q == FT_BASIC) || (ft_q == FT_L9)) begin
              load_d  = DEFAULT_LOAD;
              state_d = after_hdr(hdr_word, ft_q);
            end else begin
              state_d = ST_LOAD_LO;
            end
          end
        end

        ST_LOAD_LO: begin
          if (accept) begin
            lo_d    = ioctl_dout;
            state_d = ST_LOAD_HI;
          end
        end

        ST_LOAD_HI: begin
          if (accept) begin
            load_d  = (FORCE_LOAD != 0) ? DEFAULT_LOAD : hdr_word;
            state_d = (ft_q == FT_MCODE) ? ST_EXEC_LO : after_hdr(rem_q, ft_q);
          end
        end

        ST_EXEC_LO: begin
          if (accept) begin
            lo_d    = ioctl_dout;
            state_d = ST_EXEC_HI;
          end
        end

        ST_EXEC_HI: begin
          if (accept) begin
            exec_d       = hdr_word;
            exec_valid_d = 1'b1;
            state_d      = after_hdr(rem_q, ft_q);
          end
        end

        ST_DATA: begin
          if (rem_q == '0) begin
            // Only BASIC lingers here: its last write must land before DONE.
            if (!busy) begin
              state_d = ST_DONE;
            end
          end else if (accept) begin
            rem_d = rem_q - ADDR_W'(1);
            off_d = off_q + ADDR_W'(1);
`ifdef TAP_CHECKSUM_EN
            csum_d = csum_q + ioctl_dout;
`endif
            if (wr_addr_ext[ADDR_W]) begin
              err_d[ERR_TRUNC] = 1'b1;
            end else begin
              push = 1'b1;
            end
            // Non-BASIC files move on immediately so the check byte is
            // never swallowed by the body.
            if ((rem_q == ADDR_W'(1)) && (ft_q != FT_BASIC)) begin
              state_d = ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (accept) begin
`ifdef TAP_CHECKSUM_EN
            if (ioctl_dout != csum_q) begin
              err_d[ERR_CSUM] = 1'b1;
            end
`endif
            state_d = ST_TRAIL;
          end
        end

        ST_TRAIL: begin
          if (accept) begin
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  tap_wr_buf #(
    .ADDR_W (ADDR_W)
  ) u_wr_buf (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .addr_i     (push_addr),
    .data_i     (ioctl_dout),
    .mem_ack_i  (mem_ack),
    .mem_wr_o   (mem_wr),
    .mem_addr_o (mem_addr),
    .mem_dout_o (mem_dout),
    .busy_o     (busy)
  );

  assign ioctl_wait = busy;
  assign file_type  = ft_q;
  assign load_addr  = load_q;
  assign exec_addr  = exec_q;
  assign exec_valid = exec_valid_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_tap_loader.sv
// Scoreboard bench for tap_loader: expected RAM writes are queued as body
// bytes are sent and matched against the memory port as writes complete.
module tb_tap_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic [7:0]  file_type;
  logic [15:0] load_addr;
  logic [15:0] exec_addr;
  logic        exec_valid;
  logic        done;
  logic [2:0]  error;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  logic [23:0] exp_q[$];

  tap_loader #(
    .ADDR_W       (16),
    .DEFAULT_LOAD (16'h694D),
    .FORCE_LOAD   (0),
    .MAX_NAME     (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_ack        (mem_ack),
    .file_type      (file_type),
    .load_addr      (load_addr),
    .exec_addr      (exec_addr),
    .exec_valid     (exec_valid),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // RAM model: acknowledges each write after ack_delay idle cycles and
  // scores it against the expected queue.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_wr) begin
        if (wcnt >= ack_delay) begin
          check_val("wait_hi", {31'd0, ioctl_wait}, 32'd1);
          if (exp_q.size() == 0) begin
            check_val("spurious_wr", {16'd0, mem_addr}, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            check_val("wr_addr", {16'd0, mem_addr}, {16'd0, e[23:8]});
            check_val("wr_data", {24'd0, mem_dout}, {24'd0, e[7:0]});
          end
          $display("write %04h = %02h", mem_addr, mem_dout);
          n_writes++;
          mem_ack = 1'b1;
          wcnt    = 0;
        end else begin
          check_val("wait_hold", {31'd0, ioctl_wait}, 32'd1);
          wcnt++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    while (ioctl_wait && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check_val("wait_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  // Body bytes: queue the expected write unless the address would wrap.
  task automatic send_data(input logic [15:0] base, input logic [7:0] d[$]);
    logic [16:0] a;
    foreach (d[i]) begin
      a = {1'b0, base} + 17'(i);
      if (!a[16]) exp_q.push_back({a[15:0], d[i]});
      send_byte(d[i]);
    end
  endtask

  task automatic start_dl();
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_val("done", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_file(input string tag, input logic [2:0] exp_err);
    wait_done();
    check_val({tag, "_err"}, {29'd0, error}, {29'd0, exp_err});
    check_val({tag, "_qempty"}, exp_q.size(), 32'd0);
    $display("file %s: type %02h load %04h error %03b", tag, file_type, load_addr, error);
    end_dl();
  endtask

  initial begin
    logic [7:0]  nm[$];
    logic [2:0]  csum_err;
    int          w0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_done",  {31'd0, done},       32'd0);
    check_val("rst_err",   {29'd0, error},      32'd0);
    check_val("rst_memwr", {31'd0, mem_wr},     32'd0);
    check_val("rst_wait",  {31'd0, ioctl_wait}, 32'd0);
    check_val("rst_load",  {16'd0, load_addr},  32'd0);
    check_val("rst_ft",    {24'd0, file_type},  32'd0);
    reset = 1'b0;

    // BASIC, default load address
    start_dl();
    send_seq('{8'h22, 8'h22, 8'h42, 8'h03, 8'h00});
    send_data(16'h694D, '{8'h11, 8'h22, 8'h33});
    wait_done();
    check_val("bas_load", {16'd0, load_addr}, 32'h694D);
    check_val("bas_ft", {24'd0, file_type}, 32'h42);
    finish_file("basic", 3'b000);

    // Machine code with header load and exec addresses
    start_dl();
    send_seq('{8'h22, 8'h41, 8'h42, 8'h22, 8'h4D, 8'h02, 8'h00, 8'h00, 8'h80, 8'h10, 8'h80});
    send_data(16'h8000, '{8'hAA, 8'hBB});
    send_seq('{8'h65, 8'h00});
    wait_done();
    check_val("mc_exec", {16'd0, exec_addr}, 32'h8010);
    check_val("mc_execv", {31'd0, exec_valid}, 32'd1);
    check_val("mc_load", {16'd0, load_addr}, 32'h8000);
    finish_file("mcode", 3'b000);

    // Backpressure: every write held off for 5 cycles
    start_dl();
    @(negedge clk);
    check_val("bp_execv_clr", {31'd0, exec_valid}, 32'd0);
    ack_delay = 5;
    send_seq('{8'h22, 8'h22, 8'hA5, 8'h44, 8'h04, 8'h00, 8'h00, 8'h90});
    send_data(16'h9000, '{8'h01, 8'h02, 8'h03, 8'h04});
    send_seq('{8'h0A, 8'h00});
    finish_file("backpr", 3'b000);
    ack_delay = 0;

    // Checksum mismatch on a data file
`ifdef TAP_CHECKSUM_EN
    csum_err = 3'b100;
`else
    csum_err = 3'b000;
`endif
    start_dl();
    send_seq('{8'h22, 8'h22, 8'h44, 8'h02, 8'h00, 8'h00, 8'hA0});
    send_data(16'hA000, '{8'h3F, 8'h40});
    send_seq('{8'h00, 8'h00});
    finish_file("csum", csum_err);

    // Overflow at the top of memory: last byte suppressed
    start_dl();
    send_seq('{8'h22, 8'h22, 8'h44, 8'h03, 8'h00, 8'hFE, 8'hFF});
    send_data(16'hFFFE, '{8'h01, 8'h02, 8'h03});
    send_seq('{8'h06, 8'h00});
    finish_file("ovfl", 3'b010);

    // Bad type byte: no writes at all
    w0 = n_writes;
    start_dl();
    send_seq('{8'h22, 8'h22, 8'h5A, 8'h01, 8'h00, 8'h77});
    finish_file("badtype", 3'b001);
    check_val("badtype_nowr", n_writes, w0);

    // Name of exactly MAX_NAME bytes is fine; BASIC of length 0 writes nothing
    nm = {};
    nm.push_back(8'h22);
    for (int i = 0; i < 64; i++) nm.push_back(8'h78);
    nm.push_back(8'h22);
    nm.push_back(8'h42);
    nm.push_back(8'h00);
    nm.push_back(8'h00);
    w0 = n_writes;
    start_dl();
    send_seq(nm);
    finish_file("name64", 3'b000);
    check_val("len0_nowr", n_writes, w0);

    // One byte more overruns the name
    nm = {};
    nm.push_back(8'h22);
    for (int i = 0; i < 65; i++) nm.push_back(8'h78);
    start_dl();
    send_seq(nm);
    finish_file("name65", 3'b001);

    // Truncated download after 2 of 4 body bytes
    start_dl();
    send_seq('{8'h22, 8'h22, 8'h44, 8'h04, 8'h00, 8'h00, 8'hB0});
    send_data(16'hB000, '{8'h01, 8'h02});
    @(negedge clk);
    ioctl_download = 1'b0;
    wait_done();
    check_val("trunc_err", {29'd0, error}, 32'd2);
    check_val("trunc_qempty", exp_q.size(), 32'd0);

    // Reset in the middle of a load with a write still pending
    ack_delay = 3;
    start_dl();
    send_seq('{8'h22, 8'h22, 8'h42, 8'h04, 8'h00});
    send_data(16'h694D, '{8'h55});
    check_val("mid_wr_pend", {31'd0, mem_wr}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("mid_rst_memwr", {31'd0, mem_wr},     32'd0);
    check_val("mid_rst_wait",  {31'd0, ioctl_wait}, 32'd0);
    check_val("mid_rst_load",  {16'd0, load_addr},  32'd0);
    check_val("mid_rst_ft",    {24'd0, file_type},  32'd0);
    check_val("mid_rst_done",  {31'd0, done},       32'd0);
    check_val("mid_rst_err",   {29'd0, error},      32'd0);
    exp_q.delete();
    ioctl_download = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
